// File: rtl/prod_frame_accum.sv
// Frame accumulator: sums every K unsigned products from the array multiplier
// and presents each frame total on a registered valid/ready output.
module prod_frame_accum #(
    parameter int unsigned M = 4,
    parameter int unsigned N = 4,
    parameter int unsigned K = 4,
    localparam int unsigned PW = M + N,
    localparam int unsigned CW = $clog2(K),
    localparam int unsigned AW = PW + CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [PW-1:0] in_product,
    output logic          in_ready,
    output logic          out_valid,
    output logic [AW-1:0] out_sum,
    input  logic          out_ready
);

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_nxt;
    logic [AW-1:0] sum;
    logic [AW-1:0] out_sum_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          out_valid_nxt;
    logic          last;
    logic          accept;

    assign last     = (cnt == CW'(K - 1));
    // Only the closing product of a frame has to wait for the previous total to drain.
    assign in_ready = rst_n & ~flush & ~(last & out_valid & ~out_ready);
    assign accept   = in_valid & in_ready;
    assign sum      = acc + AW'(in_product);

    always_comb begin
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        out_valid_nxt = out_valid;
        out_sum_nxt   = out_sum;

        if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end

        if (flush) begin
            acc_nxt = '0;
            cnt_nxt = '0;
        end else if (accept) begin
            if (last) begin
                // A completing frame overrides a same-edge drain, keeping out_valid high.
                out_sum_nxt   = sum;
                out_valid_nxt = 1'b1;
                acc_nxt       = '0;
                cnt_nxt       = '0;
            end else begin
                acc_nxt = sum;
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else begin
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            out_valid <= out_valid_nxt;
            out_sum   <= out_sum_nxt;
        end
    end

endmodule

// File: tb/tb_prod_frame_accum.sv
// Bench for prod_frame_accum: directed vector table, reset sequence and a
// randomized soak against a frame-total scoreboard.
module tb_prod_frame_accum;

    localparam int unsigned M  = 4;
    localparam int unsigned N  = 4;
    localparam int unsigned K  = 4;
    localparam int unsigned PW = M + N;
    localparam int unsigned AW = PW + $clog2(K);
    localparam int unsigned SOAK_FRAMES = 1000;
    localparam int unsigned SOAK_CYCLES = 60000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [PW-1:0] in_product;
    logic          in_ready;
    logic          out_valid;
    logic [AW-1:0] out_sum;
    logic          out_ready;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    typedef struct {
        logic          rst_n;
        logic          flush;
        logic          in_valid;
        logic [PW-1:0] prod;
        logic          ordy;
        logic          exp_ir;
        logic          exp_ov;
        logic [AW-1:0] exp_sum;
    } vec_t;

    vec_t tbl[$];

    prod_frame_accum #(.M(M), .N(N), .K(K)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_product (in_product),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_sum    (out_sum),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic v, input int p,
                                input logic o, input logic ir, input logic ov, input int s);
        vec_t t;
        t.rst_n   = r;
        t.flush   = f;
        t.in_valid = v;
        t.prod    = PW'(p);
        t.ordy    = o;
        t.exp_ir  = ir;
        t.exp_ov  = ov;
        t.exp_sum = AW'(s);
        return t;
    endfunction

    // Drive one cycle: in_ready checked before the edge, registered outputs after it.
    task automatic apply(input vec_t v, input string tag);
        rst_n      = v.rst_n;
        flush      = v.flush;
        in_valid   = v.in_valid;
        in_product = v.prod;
        out_ready  = v.ordy;
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(v.exp_ir));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(v.exp_ov));
        chk({tag, " out_sum"}, 32'(out_sum), 32'(v.exp_sum));
    endtask

    initial begin
        int unsigned   pos;
        int unsigned   drained;
        int unsigned   cyc;
        logic [AW-1:0] part;
        logic [AW-1:0] q[$];
        logic [PW-1:0] cur;
        logic          hold;
        logic          exp_ir;
        logic          took;
        logic          drain;
        int unsigned   a;
        int unsigned   b;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_product = '0; out_ready = 1'b0;

        // Reset, then a full-scale frame of 225s drained immediately
        tbl.push_back(mk(0, 0, 0, 0,   1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 225, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 225, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 225, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 225, 1, 1, 1, 900));
        tbl.push_back(mk(1, 0, 0, 0,   1, 1, 0, 900));
        // Back-pressure: total 20 held while the next frame fills, 4th product stalls
        tbl.push_back(mk(1, 0, 1, 2, 0, 1, 0, 900));
        tbl.push_back(mk(1, 0, 1, 4, 0, 1, 0, 900));
        tbl.push_back(mk(1, 0, 1, 6, 0, 1, 0, 900));
        tbl.push_back(mk(1, 0, 1, 8, 0, 1, 1, 20));
        tbl.push_back(mk(1, 0, 1, 1, 0, 1, 1, 20));
        tbl.push_back(mk(1, 0, 1, 1, 0, 1, 1, 20));
        tbl.push_back(mk(1, 0, 1, 1, 0, 1, 1, 20));
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 1, 20));
        tbl.push_back(mk(1, 0, 1, 1, 1, 1, 1, 4));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 4));
        // Flush drops 10+20 and refuses the 99 offered alongside it
        tbl.push_back(mk(1, 0, 1, 10, 1, 1, 0, 4));
        tbl.push_back(mk(1, 0, 1, 20, 1, 1, 0, 4));
        tbl.push_back(mk(1, 1, 1, 99, 1, 0, 0, 4));
        tbl.push_back(mk(1, 0, 1, 5,  1, 1, 0, 4));
        tbl.push_back(mk(1, 0, 1, 5,  1, 1, 0, 4));
        tbl.push_back(mk(1, 0, 1, 5,  1, 1, 0, 4));
        tbl.push_back(mk(1, 0, 1, 5,  1, 1, 1, 20));
        tbl.push_back(mk(1, 0, 0, 0,  1, 1, 0, 20));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset mid-frame with an undrained total of 28 pending
        for (int i = 0; i < 3; i++) apply(mk(1, 0, 1, 7, 0, 1, 0, 20), "rst_fill");
        apply(mk(1, 0, 1, 7, 0, 1, 1, 28), "rst_total");
        apply(mk(1, 0, 1, 2, 0, 1, 1, 28), "rst_part1");
        apply(mk(1, 0, 1, 2, 0, 1, 1, 28), "rst_part2");
        apply(mk(0, 0, 1, 2, 0, 0, 0, 0),  "rst_edge");
        for (int i = 0; i < 3; i++) apply(mk(1, 0, 1, 3, 1, 1, 0, 0), "post_rst");
        apply(mk(1, 0, 1, 3, 1, 1, 1, 12), "post_rst_total");
        apply(mk(1, 0, 0, 0, 1, 1, 0, 12), "post_rst_drain");

        // Random soak; scoreboard holds completed-but-undrained frame totals
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0), "soak_rst");
        pos = 0; part = '0; drained = 0; hold = 1'b0; cur = '0; cyc = 0;
        while (drained < SOAK_FRAMES && cyc < SOAK_CYCLES) begin
            cyc++;
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = $urandom_range(0, (1 << M) - 1);
                b = $urandom_range(0, (1 << N) - 1);
                cur = PW'(a * b);
            end
            rst_n = 1'b1; flush = 1'b0;
            in_product = cur;
            out_ready  = ($urandom_range(0, 1) == 1);
            #1;
            exp_ir = !(pos == K - 1 && q.size() > 0 && !out_ready);
            chk("soak in_ready", 32'(in_ready), 32'(exp_ir));
            took  = in_valid && in_ready;
            drain = (q.size() > 0) && out_ready;
            @(posedge clk);
            #1;
            if (drain) begin
                void'(q.pop_front());
                drained++;
            end
            if (took) begin
                part = part + AW'(cur);
                pos++;
                if (pos == K) begin
                    q.push_back(part);
                    part = '0;
                    pos = 0;
                end
            end
            hold = in_valid && !took;
            chk("soak out_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0) chk("soak out_sum", 32'(out_sum), 32'(q[0]));
        end
        chk("soak frames drained", drained, SOAK_FRAMES);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
